// File: rtl/dma_csr_wb_if.sv
// Wishbone slave bus bundle for the DMA CSR block.
// master drives cyc/stb/we/sel/adr/dat_i; slave returns dat_o/ack/err/rty.
interface dma_csr_wb_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  wbs_rty_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output wbs_rty_o
  );
endinterface

// File: rtl/dma_csr_wb.sv
// DMA CSR Wishbone slave: per-channel CCR/STAT/DAR/NDAR plus ID/INTSTAT.
// Ports: wb_clk_i, wb_rst_i, wbs (bus), busy/done/dar/clear in, control out.
// Optional DMA_CSR_BYTE_SEL_EN: honour wbs_sel_i byte lanes on writes.
module dma_csr_wb #(
  parameter int          NCH = 2,
  parameter logic [15:0] ID  = 16'hAA55
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  dma_csr_wb_if.slave       wbs,
  input  logic [NCH-1:0]    busy_i,
  input  logic [NCH-1:0]    done_i,
  input  logic [NCH*32-1:0] dar_i,
  input  logic [NCH-1:0]    ndar_clear_i,
  input  logic [NCH-1:0]    append_clear_i,
  output logic [NCH-1:0]    enable_o,
  output logic [NCH-1:0]    append_o,
  output logic [NCH-1:0]    ndar_dirty_o,
  output logic [NCH*29-1:0] ndar_o,
  output logic              int_o
);

  logic [NCH-1:0]       app_q, en_q, ie_q, pend_q, dirty_q;
  logic [NCH-1:0]       app_n, en_n, ie_n, pend_n, dirty_n;
  logic [NCH-1:0][28:0] ndar_q, ndar_n;
  logic [NCH-1:0]       hit;
  logic [31:0]          adr, wd, wmask, rdata, nmrg;
  logic [31:0]          dat_q;
  logic                 ack_q, err_q, int_q;
  logic                 acc, glob, ch_ok, bad, wr, w1c;
  logic [3:0]           ch;
  logic [1:0]           rs;
  logic                 unused_bits;

  assign adr = wbs.wbs_adr_i;
  assign wd  = wbs.wbs_dat_i;
  assign glob = adr[9];
  assign ch  = adr[7:4];
  assign rs  = adr[3:2];
  assign unused_bits = ^{adr[31:11], adr[8], adr[1:0], wbs.wbs_sel_i};

`ifdef DMA_CSR_BYTE_SEL_EN
  assign wmask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                  {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
`else
  assign wmask = '1;
`endif

  // The cycle carrying a response never starts a new access.
  assign acc   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~(ack_q | err_q);
  assign ch_ok = ch < 4'(NCH);
  assign bad   = ~adr[10] | (~glob & ~ch_ok) |
                 (~glob & (rs == 2'd3) & wbs.wbs_we_i & |(hit & en_q));
  assign wr    = acc & wbs.wbs_we_i & ~bad;
  assign w1c   = wd[0] & wmask[0];

  always_comb begin
    hit     = '0;
    app_n   = app_q;
    en_n    = en_q;
    ie_n    = ie_q;
    pend_n  = pend_q;
    dirty_n = dirty_q;
    ndar_n  = ndar_q;
    nmrg    = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c] = ~glob & (ch == 4'(c));
      if (wr && hit[c] && rs == 2'd0 && wmask[0]) begin
        app_n[c] = wd[0];
        en_n[c]  = wd[1];
        ie_n[c]  = wd[2];
      end else if (append_clear_i[c]) begin
        app_n[c] = 1'b0;
      end
      if (wr && hit[c] && rs == 2'd1 && w1c)
        pend_n[c] = 1'b0;
      if (done_i[c])
        pend_n[c] = 1'b1;
      nmrg = ({ndar_q[c], 3'b000} & ~wmask) | (wd & wmask);
      if (wr && hit[c] && rs == 2'd3) begin
        ndar_n[c]  = nmrg[31:3];
        dirty_n[c] = 1'b1;
      end else if (ndar_clear_i[c]) begin
        dirty_n[c] = 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (glob) begin
      unique case (rs)
        2'd0:    rdata = {8'h00, 8'(NCH), ID};
        2'd1:    rdata = 32'(pend_q);
        default: rdata = '0;
      endcase
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hit[c]) begin
          unique case (rs)
            2'd0: rdata = {29'd0, ie_q[c], en_q[c], app_q[c]};
            2'd1: rdata = {30'd0, busy_i[c], pend_q[c]};
            2'd2: rdata = dar_i[32*c +: 32];
            2'd3: rdata = {ndar_q[c], 3'b000};
          endcase
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      app_q   <= '0;
      en_q    <= '0;
      ie_q    <= '0;
      pend_q  <= '0;
      dirty_q <= '0;
      ndar_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      int_q   <= 1'b0;
    end else begin
      app_q   <= app_n;
      en_q    <= en_n;
      ie_q    <= ie_n;
      pend_q  <= pend_n;
      dirty_q <= dirty_n;
      ndar_q  <= ndar_n;
      ack_q   <= acc & ~bad;
      err_q   <= acc & bad;
      if (acc)
        dat_q <= bad ? 32'd0 : rdata;
      // Built from next state so it tracks pending with no extra lag.
      int_q   <= |(pend_n & ie_n);
    end
  end

  assign wbs.wbs_dat_o = dat_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign wbs.wbs_rty_o = 1'b0;
  assign enable_o      = en_q;
  assign append_o      = app_q;
  assign ndar_dirty_o  = dirty_q;
  assign ndar_o        = ndar_q;
  assign int_o         = int_q;

endmodule

// File: tb/tb_dma_csr_wb.sv
// Directed self-checking bench for dma_csr_wb with NCH=2.
// Drives Wishbone through the interface, checks responses and outputs.
module tb_dma_csr_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  busy = '0, done = '0, nclr = '0, aclr = '0;
  logic [63:0] dar = 64'hCAFE_0010_BEEF_0020;
  logic [1:0]  en, app, dirty;
  logic [57:0] ndar;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic        ak, er;
  logic [31:0] q;
  logic [28:0] ndar1_prev;

  dma_csr_wb_if wb();

  dma_csr_wb #(.NCH(2), .ID(16'hAA55)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wb.slave),
    .busy_i(busy), .done_i(done), .dar_i(dar),
    .ndar_clear_i(nclr), .append_clear_i(aclr),
    .enable_o(en), .append_o(app), .ndar_dirty_o(dirty),
    .ndar_o(ndar), .int_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic rak, output logic rer,
                     output logic [31:0] rq);
    int n;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = w;
    wb.wbs_adr_i = a; wb.wbs_dat_i = d; wb.wbs_sel_i = s;
    @(posedge clk); #1;
    n = 0;
    while (!(wb.wbs_ack_o || wb.wbs_err_o) && n < 4) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'd0);
    rak = wb.wbs_ack_o; rer = wb.wbs_err_o; rq = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    bus(1'b0, a, 32'd0, 4'hF, ak, er, q);
    chk({tag, "_ack"}, 64'(ak), 64'd1);
    chk(tag, 64'(q), 64'(exp));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input string tag);
    bus(1'b1, a, d, 4'hF, ak, er, q);
    chk({tag, "_ack"}, 64'(ak), 64'd1);
  endtask

  initial begin
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
    chk("rst_err", 64'(wb.wbs_err_o), 64'd0);
    chk("rst_dat", 64'(wb.wbs_dat_o), 64'd0);
    chk("rst_int", 64'(irq), 64'd0);
    chk("rst_ctl", 64'({en, app, dirty}), 64'd0);
    chk("rst_ndar", 64'(ndar), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    rd(32'h600, 32'h0002_AA55, "id");
    bus(1'b0, 32'h000, 32'd0, 4'hF, ak, er, q);
    chk("a10_err", 64'({ak, er}), 64'b01);
    chk("rty", 64'(wb.wbs_rty_o), 64'd0);

    wr(32'h410, 32'h0, "ccr1");
    wr(32'h41C, 32'h1234_5678, "ndar1");
    chk("ndar1_o", 64'(ndar[57:29]), 64'h0246_8ACF);
    chk("dirty1", 64'(dirty), 64'b10);
    rd(32'h41C, 32'h1234_5678, "ndar1_rd");
    rd(32'h418, 32'hCAFE_0010, "dar1_rd");
    nclr = 2'b10;
    @(posedge clk); #1;
    nclr = 2'b00;
    chk("dirty_clr", 64'(dirty), 64'b00);

    wr(32'h410, 32'h2, "ccr1_en");
    chk("en1", 64'(en), 64'b10);
    ndar1_prev = ndar[57:29];
    bus(1'b1, 32'h41C, 32'hDEAD_BEE8, 4'hF, ak, er, q);
    chk("ndar_en_err", 64'({ak, er}), 64'b01);
    chk("ndar_keep", 64'(ndar[57:29]), 64'(ndar1_prev));
    chk("dirty_keep", 64'(dirty), 64'b00);

    wr(32'h400, 32'h4, "ccr0_ie");
    done = 2'b01;
    @(posedge clk); #1;
    done = 2'b00;
    chk("int_rise", 64'(irq), 64'd1);
    rd(32'h604, 32'h1, "intstat");
    busy = 2'b01;
    rd(32'h404, 32'h3, "stat0");
    busy = 2'b00;
    wr(32'h404, 32'h1, "w1c");
    chk("int_fall", 64'(irq), 64'd0);
    rd(32'h604, 32'h0, "intstat0");

    fork
      bus(1'b1, 32'h404, 32'h1, 4'hF, ak, er, q);
      begin
        done = 2'b01;
        @(posedge clk); #1;
        done = 2'b00;
      end
    join
    chk("set_wins", 64'(irq), 64'd1);
    rd(32'h604, 32'h1, "intstat_sw");

    fork
      bus(1'b1, 32'h400, 32'h5, 4'hF, ak, er, q);
      begin
        aclr = 2'b01;
        @(posedge clk); #1;
        aclr = 2'b00;
      end
    join
    chk("app_wins", 64'(app), 64'b01);
    aclr = 2'b01;
    @(posedge clk); #1;
    aclr = 2'b00;
    chk("app_clr", 64'(app), 64'b00);

    bus(1'b0, 32'h430, 32'd0, 4'hF, ak, er, q);
    chk("ch3_rd_err", 64'({ak, er}), 64'b01);
    bus(1'b1, 32'h430, 32'hFFFF_FFFF, 4'hF, ak, er, q);
    chk("ch3_wr_err", 64'({ak, er}), 64'b01);
    chk("ch3_noeff", 64'({en, app, dirty}), 64'b10_00_00);

    bus(1'b1, 32'h40C, 32'hFFFF_FFF8, 4'b0011, ak, er, q);
    chk("bsel_ack", 64'(ak), 64'd1);
`ifdef DMA_CSR_BYTE_SEL_EN
    rd(32'h40C, 32'h0000_FFF8, "bsel_rd");
`else
    rd(32'h40C, 32'hFFFF_FFF8, "bsel_rd");
`endif

    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = 32'h400; wb.wbs_dat_i = 32'h2; wb.wbs_sel_i = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    chk("rst_mid_ack", 64'({wb.wbs_ack_o, wb.wbs_err_o}), 64'b00);
    chk("rst_mid_ctl", 64'({en, app, dirty, irq}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_after", 64'({wb.wbs_ack_o, en}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
